// File: rtl/fwd_lkp_arb_pkg.sv
// Shared constants, tag type and round-robin pointer helpers for the forwarding-lookup arbiter.
package fwd_lkp_arb_pkg;
    localparam int CHANNEL_NUM = 4;
    localparam int FWD_AW      = 8;
    localparam int FWD_DW      = 12 + CHANNEL_NUM;
    localparam int IDX_W       = 3;

    typedef logic [IDX_W-1:0] req_idx_t;

    typedef struct packed {
        logic     vld;
        req_idx_t idx;
    } tag_t;

    // k-th candidate of a rotation over lo..lo+span-1 that starts at base
    function automatic req_idx_t rr_cand(input req_idx_t base, input int k, input int lo, input int span);
        return req_idx_t'(lo + ((int'(base) - lo + k) % span));
    endfunction

    function automatic req_idx_t wrap_inc(input req_idx_t g, input int lo, input int hi);
        return (int'(g) == hi) ? req_idx_t'(lo) : req_idx_t'(int'(g) + 1);
    endfunction
endpackage

// File: rtl/fwd_lkp_arb_if.sv
// Requester handshake plus forwarding-table read port of the lookup arbiter.
interface fwd_lkp_arb_if import fwd_lkp_arb_pkg::*; #(
    parameter int REQ_NUM = 4,
    parameter int AW      = FWD_AW,
    parameter int DW      = FWD_DW
);
    logic [REQ_NUM-1:0]    req_vld;
    logic [REQ_NUM*AW-1:0] req_addr;
    logic [REQ_NUM-1:0]    req_rdy;
    logic [REQ_NUM-1:0]    rsp_vld;
    logic [DW-1:0]         rsp_data;
    logic                  fwd_rden;
    logic [AW-1:0]         fwd_addr;
    logic [DW-1:0]         fwd_data;
    logic                  busy;

    modport slave (
        input  req_vld, req_addr, fwd_data,
        output req_rdy, rsp_vld, rsp_data, fwd_rden, fwd_addr, busy
    );

    modport master (
        output req_vld, req_addr, fwd_data,
        input  req_rdy, rsp_vld, rsp_data, fwd_rden, fwd_addr, busy
    );
endinterface

// File: rtl/fwd_lkp_arb_rr.sv
// Combinational round-robin grant with its pointer register.
// FWD_ARB_PRIO_EN: requester 0 gets strict priority, the rest rotate over 1..REQ_NUM-1.
module fwd_rr_arb import fwd_lkp_arb_pkg::*; #(
    parameter int REQ_NUM = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REQ_NUM-1:0] req,
    input  logic               take,
    output logic [REQ_NUM-1:0] gnt,
    output req_idx_t           idx
);
`ifdef FWD_ARB_PRIO_EN
    localparam int RR_LO = 1;
`else
    localparam int RR_LO = 0;
`endif
    localparam int                 RR_SPAN  = REQ_NUM - RR_LO;
    localparam req_idx_t           PTR_RST  = req_idx_t'(RR_LO);
    localparam logic [REQ_NUM-1:0] ONE_HOT0 = {{(REQ_NUM-1){1'b0}}, 1'b1};

    req_idx_t           ptr_r;
    req_idx_t           ptr_next_s;
    req_idx_t           cand_s;
    req_idx_t           rr_idx_s;
    logic [REQ_NUM-1:0] rr_gnt_s;
    logic               found_s;
    logic               hit_s;

    // first requesting candidate of the rotation starting at ptr_r
    always_comb begin
        rr_gnt_s = '0;
        rr_idx_s = '0;
        found_s  = 1'b0;
        cand_s   = '0;
        hit_s    = 1'b0;
        for (int k = 0; k < RR_SPAN; k++) begin
            cand_s = rr_cand(ptr_r, k, RR_LO, RR_SPAN);
            for (int i = RR_LO; i < REQ_NUM; i++) begin
                hit_s       = !found_s && (cand_s == req_idx_t'(i)) && req[i];
                rr_gnt_s[i] = rr_gnt_s[i] | hit_s;
                rr_idx_s    = hit_s ? cand_s : rr_idx_s;
                found_s     = found_s | hit_s;
            end
        end
    end

`ifdef FWD_ARB_PRIO_EN
    assign gnt = req[0] ? ONE_HOT0 : rr_gnt_s;
    assign idx = req[0] ? req_idx_t'(0) : rr_idx_s;
`else
    assign gnt = rr_gnt_s;
    assign idx = rr_idx_s;
`endif

    // requester-0 priority grants never move the rotation
    always_comb begin
        ptr_next_s = (take && (int'(idx) >= RR_LO)) ? wrap_inc(idx, RR_LO, REQ_NUM - 1) : ptr_r;
    end

    // pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= PTR_RST;
        end else begin
            ptr_r <= ptr_next_s;
        end
    end

    wire unused_ok = &{1'b0, ONE_HOT0};
endmodule

// File: rtl/fwd_lkp_arb.sv
// Shares the forwarding-table lookup port among REQ_NUM engines and routes data back by tag.
// Build option FWD_ARB_PRIO_EN selects strict priority for requester 0 (see fwd_rr_arb).
module fwd_lkp_arb import fwd_lkp_arb_pkg::*; #(
    parameter int REQ_NUM = 4,
    parameter int LKP_LAT = 1,
    parameter int AW      = FWD_AW,
    parameter int DW      = FWD_DW
) (
    input logic         clk,
    input logic         rst,
    fwd_lkp_arb_if.slave bus
);
    logic [REQ_NUM-1:0] req_m_s;
    logic [REQ_NUM-1:0] gnt_s;
    req_idx_t           gnt_idx_s;
    logic               take_s;
    logic [AW-1:0]      sel_addr_s;

    logic               fwd_rden_r;
    logic [AW-1:0]      fwd_addr_r;
    req_idx_t           issue_idx_r;
    tag_t               pipe_r [LKP_LAT];
    tag_t               last_s;
    logic               pipe_any_s;
    logic [REQ_NUM-1:0] rsp_dec_s;
    logic [REQ_NUM-1:0] rsp_vld_r;
    logic [DW-1:0]      rsp_data_r;

    // no grants while reset is held
    assign req_m_s = bus.req_vld & {REQ_NUM{~rst}};
    assign take_s  = |gnt_s;

    fwd_rr_arb #(.REQ_NUM(REQ_NUM)) u_rr (
        .clk  (clk),
        .rst  (rst),
        .req  (req_m_s),
        .take (take_s),
        .gnt  (gnt_s),
        .idx  (gnt_idx_s)
    );

    // one-hot address mux driven by the grant
    always_comb begin
        sel_addr_s = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            sel_addr_s = sel_addr_s | (bus.req_addr[i*AW +: AW] & {AW{gnt_s[i]}});
        end
    end

    // issue stage: table read enable, address and owner of the read
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_rden_r  <= 1'b0;
            fwd_addr_r  <= '0;
            issue_idx_r <= '0;
        end else begin
            fwd_rden_r  <= take_s;
            fwd_addr_r  <= take_s ? sel_addr_s : fwd_addr_r;
            issue_idx_r <= take_s ? gnt_idx_s : issue_idx_r;
        end
    end

    // tag pipeline fed from the issued read so the last stage lines up with fwd_data
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LKP_LAT; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= tag_t'{vld: fwd_rden_r, idx: issue_idx_r};
            for (int i = 1; i < LKP_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // response decode and in-flight summary
    always_comb begin
        last_s     = pipe_r[LKP_LAT-1];
        pipe_any_s = 1'b0;
        for (int i = 0; i < LKP_LAT; i++) begin
            pipe_any_s = pipe_any_s | pipe_r[i].vld;
        end
        for (int i = 0; i < REQ_NUM; i++) begin
            rsp_dec_s[i] = last_s.vld && (last_s.idx == req_idx_t'(i));
        end
    end

    // response register
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_r  <= '0;
            rsp_data_r <= '0;
        end else begin
            rsp_vld_r  <= rsp_dec_s;
            rsp_data_r <= last_s.vld ? bus.fwd_data : rsp_data_r;
        end
    end

    assign bus.req_rdy  = gnt_s;
    assign bus.fwd_rden = fwd_rden_r;
    assign bus.fwd_addr = fwd_addr_r;
    assign bus.rsp_vld  = rsp_vld_r;
    assign bus.rsp_data = rsp_data_r;
    assign bus.busy     = fwd_rden_r | pipe_any_s | (|rsp_vld_r);
endmodule

// File: tb/tb_fwd_lkp_arb.sv
// Directed bench for fwd_lkp_arb: one instance with LKP_LAT=1, one with LKP_LAT=3, each with a table model.
module tb_fwd_lkp_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fwd_lkp_arb_if #(.REQ_NUM(4), .AW(8), .DW(16)) bus1 ();
    fwd_lkp_arb_if #(.REQ_NUM(4), .AW(8), .DW(16)) bus3 ();

    fwd_lkp_arb #(.REQ_NUM(4), .LKP_LAT(1), .AW(8), .DW(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    fwd_lkp_arb #(.REQ_NUM(4), .LKP_LAT(3), .AW(8), .DW(16)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // table models: data = {8'h00, addr ^ 8'h99}, LKP_LAT cycles after the read
    logic [15:0] t1_r;
    logic [15:0] t3_r [3];
    always @(posedge clk) begin
        t1_r <= bus1.fwd_rden ? {8'h00, bus1.fwd_addr ^ 8'h99} : t1_r;
    end
    always @(posedge clk) begin
        t3_r[0] <= bus3.fwd_rden ? {8'h00, bus3.fwd_addr ^ 8'h99} : t3_r[0];
        t3_r[1] <= t3_r[0];
        t3_r[2] <= t3_r[1];
    end
    assign bus1.fwd_data = t1_r;
    assign bus3.fwd_data = t3_r[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus1.req_vld = 4'hF; bus1.req_addr = 32'h0;
        bus3.req_vld = 4'hF; bus3.req_addr = 32'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++; if (bus1.req_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy1 got %b exp %b", bus1.req_rdy, 4'b0000); end
        n_checks++; if (bus3.req_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy3 got %b exp %b", bus3.req_rdy, 4'b0000); end
        n_checks++; if (bus1.fwd_rden !== 1'b0) begin n_fail++; $display("FAIL reset_rden got %b exp 0", bus1.fwd_rden); end
        n_checks++; if (bus1.fwd_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h exp 00", bus1.fwd_addr); end
        n_checks++; if (bus1.rsp_vld !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_vld got %b exp 0000", bus1.rsp_vld); end
        n_checks++; if (bus1.rsp_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_data got %h exp 0000", bus1.rsp_data); end
        n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got %b exp 0", bus1.busy); end
        n_checks++; if (bus3.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy3 got %b exp 0", bus3.busy); end
        rst = 1'b0;
        bus1.req_vld = 4'h0;
        bus3.req_vld = 4'h0;
        tick();
    endtask

    task automatic test_single();
        bus1.req_vld = 4'b0100; bus1.req_addr = 32'h003C_0000;
        #1;
        n_checks++; if (bus1.req_rdy !== 4'b0100) begin n_fail++; $display("FAIL single_rdy got %b exp %b", bus1.req_rdy, 4'b0100); end
        tick(); bus1.req_vld = 4'b0000; #1;
        n_checks++; if (bus1.fwd_rden !== 1'b1) begin n_fail++; $display("FAIL single_rden got %b exp 1", bus1.fwd_rden); end
        n_checks++; if (bus1.fwd_addr !== 8'h3C) begin n_fail++; $display("FAIL single_addr got %h exp 3c", bus1.fwd_addr); end
        n_checks++; if (bus1.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", bus1.busy); end
        tick();
        n_checks++; if (bus1.fwd_rden !== 1'b0) begin n_fail++; $display("FAIL single_rden_low got %b exp 0", bus1.fwd_rden); end
        n_checks++; if (bus1.fwd_addr !== 8'h3C) begin n_fail++; $display("FAIL single_addr_hold got %h exp 3c", bus1.fwd_addr); end
        n_checks++; if (bus1.rsp_vld !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_early got %b exp 0000", bus1.rsp_vld); end
        tick();
        n_checks++; if (bus1.rsp_vld !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_vld got %b exp 0100", bus1.rsp_vld); end
        n_checks++; if (bus1.rsp_data !== 16'h00A5) begin n_fail++; $display("FAIL single_rsp_data got %h exp 00a5", bus1.rsp_data); end
        tick();
        n_checks++; if (bus1.rsp_vld !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_off got %b exp 0000", bus1.rsp_vld); end
        n_checks++; if (bus1.rsp_data !== 16'h00A5) begin n_fail++; $display("FAIL single_data_hold got %h exp 00a5", bus1.rsp_data); end
        n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b exp 0", bus1.busy); end
        tick();
    endtask

`ifndef FWD_ARB_PRIO_EN
    task automatic test_contention();
        logic [3:0]  exp_gnt  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [7:0]  exp_addr [4] = '{8'h20, 8'h21, 8'h22, 8'h23};
        logic [15:0] exp_data [4] = '{16'h00B9, 16'h00B8, 16'h00BB, 16'h00BA};
        rst = 1'b1; tick(); rst = 1'b0;
        bus1.req_addr = 32'h2322_2120;
        for (int c = 0; c < 12; c++) begin
            bus1.req_vld = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                n_checks++; if (bus1.req_rdy !== exp_gnt[c%4]) begin n_fail++; $display("FAIL cont_rdy c=%0d got %b exp %b", c, bus1.req_rdy, exp_gnt[c%4]); end
            end
            if (c >= 1 && c <= 8) begin
                n_checks++; if (bus1.fwd_rden !== 1'b1 || bus1.fwd_addr !== exp_addr[(c-1)%4]) begin n_fail++; $display("FAIL cont_issue c=%0d got %b/%h exp 1/%h", c, bus1.fwd_rden, bus1.fwd_addr, exp_addr[(c-1)%4]); end
            end
            if (c >= 3 && c <= 10) begin
                n_checks++; if (bus1.rsp_vld !== exp_gnt[(c-3)%4] || bus1.rsp_data !== exp_data[(c-3)%4]) begin n_fail++; $display("FAIL cont_rsp c=%0d got %b/%h exp %b/%h", c, bus1.rsp_vld, bus1.rsp_data, exp_gnt[(c-3)%4], exp_data[(c-3)%4]); end
            end else begin
                n_checks++; if (bus1.rsp_vld !== 4'b0000) begin n_fail++; $display("FAIL cont_rsp_idle c=%0d got %b exp 0000", c, bus1.rsp_vld); end
            end
            tick();
        end
    endtask
`else
    task automatic test_priority();
        logic [3:0] exp_rot [3] = '{4'b0010, 4'b0100, 4'b1000};
        rst = 1'b1; tick(); rst = 1'b0;
        bus1.req_addr = 32'h2322_2120;
        for (int c = 0; c < 10; c++) begin
            bus1.req_vld = (c < 4) ? 4'hF : 4'hE;
            #1;
            if (c < 4) begin
                n_checks++; if (bus1.req_rdy !== 4'b0001) begin n_fail++; $display("FAIL prio_rdy0 c=%0d got %b exp 0001", c, bus1.req_rdy); end
            end else begin
                n_checks++; if (bus1.req_rdy !== exp_rot[(c-4)%3]) begin n_fail++; $display("FAIL prio_rot c=%0d got %b exp %b", c, bus1.req_rdy, exp_rot[(c-4)%3]); end
            end
            tick();
        end
        bus1.req_vld = 4'h0;
        repeat (4) tick();
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0]  a [3] = '{8'h10, 8'h11, 8'h12};
        logic [15:0] d [3] = '{16'h0089, 16'h0088, 16'h008B};
        for (int c = 0; c < 7; c++) begin
            bus1.req_vld  = (c < 3) ? 4'b0010 : 4'b0000;
            bus1.req_addr = (c < 3) ? {16'h0000, a[c], 8'h00} : 32'h0;
            #1;
            if (c < 3) begin
                n_checks++; if (bus1.req_rdy !== 4'b0010) begin n_fail++; $display("FAIL b2b_rdy c=%0d got %b exp 0010", c, bus1.req_rdy); end
            end
            if (c >= 1 && c <= 3) begin
                n_checks++; if (bus1.fwd_rden !== 1'b1 || bus1.fwd_addr !== a[c-1]) begin n_fail++; $display("FAIL b2b_issue c=%0d got %b/%h exp 1/%h", c, bus1.fwd_rden, bus1.fwd_addr, a[c-1]); end
            end
            if (c == 4) begin
                n_checks++; if (bus1.fwd_rden !== 1'b0) begin n_fail++; $display("FAIL b2b_rden_end got %b exp 0", bus1.fwd_rden); end
            end
            if (c >= 3 && c <= 5) begin
                n_checks++; if (bus1.rsp_vld !== 4'b0010 || bus1.rsp_data !== d[c-3]) begin n_fail++; $display("FAIL b2b_rsp c=%0d got %b/%h exp 0010/%h", c, bus1.rsp_vld, bus1.rsp_data, d[c-3]); end
            end
            if (c == 6) begin
                n_checks++; if (bus1.rsp_vld !== 4'b0000) begin n_fail++; $display("FAIL b2b_rsp_end got %b exp 0000", bus1.rsp_vld); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_flight();
        bus1.req_vld = 4'b0010; bus1.req_addr = 32'h0000_4400;
        #1;
        n_checks++; if (bus1.req_rdy !== 4'b0010) begin n_fail++; $display("FAIL rmf_rdy got %b exp 0010", bus1.req_rdy); end
        tick(); bus1.req_vld = 4'b0000; #1;
        n_checks++; if (bus1.fwd_rden !== 1'b1 || bus1.fwd_addr !== 8'h44) begin n_fail++; $display("FAIL rmf_issue got %b/%h exp 1/44", bus1.fwd_rden, bus1.fwd_addr); end
        tick(); rst = 1'b1; bus1.req_vld = 4'hF; #1;
        n_checks++; if (bus1.req_rdy !== 4'b0000) begin n_fail++; $display("FAIL rmf_rdy_in_rst got %b exp 0000", bus1.req_rdy); end
        tick(); rst = 1'b0; bus1.req_vld = 4'h0; #1;
        n_checks++; if (bus1.fwd_rden !== 1'b0 || bus1.fwd_addr !== 8'h00) begin n_fail++; $display("FAIL rmf_fwd_clr got %b/%h exp 0/00", bus1.fwd_rden, bus1.fwd_addr); end
        n_checks++; if (bus1.rsp_data !== 16'h0000) begin n_fail++; $display("FAIL rmf_data_clr got %h exp 0000", bus1.rsp_data); end
        n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL rmf_busy got %b exp 0", bus1.busy); end
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (bus1.rsp_vld !== 4'b0000) begin n_fail++; $display("FAIL rmf_no_rsp c=%0d got %b exp 0000", c, bus1.rsp_vld); end
            tick();
        end
        // pointer is back at its reset value: 1..3 requesting selects requester 1
        bus1.req_vld = 4'hE; #1;
        n_checks++; if (bus1.req_rdy !== 4'b0010) begin n_fail++; $display("FAIL rmf_ptr got %b exp 0010", bus1.req_rdy); end
        tick(); bus1.req_vld = 4'h0;
        repeat (4) tick();
    endtask

    task automatic test_latency_sweep();
        bus3.req_vld = 4'b0001; bus3.req_addr = 32'h0000_003C;
        #1;
        n_checks++; if (bus3.req_rdy !== 4'b0001) begin n_fail++; $display("FAIL lat_rdy got %b exp 0001", bus3.req_rdy); end
        n_checks++; if (bus3.busy !== 1'b0) begin n_fail++; $display("FAIL lat_busy_pre got %b exp 0", bus3.busy); end
        tick(); bus3.req_vld = 4'b0000; #1;
        n_checks++; if (bus3.fwd_rden !== 1'b1 || bus3.fwd_addr !== 8'h3C) begin n_fail++; $display("FAIL lat_issue got %b/%h exp 1/3c", bus3.fwd_rden, bus3.fwd_addr); end
        for (int c = 1; c < 7; c++) begin
            if (c <= 4) begin
                n_checks++; if (bus3.busy !== 1'b1 || bus3.rsp_vld !== 4'b0000) begin n_fail++; $display("FAIL lat_wait c=%0d got busy %b rsp %b exp 1/0000", c, bus3.busy, bus3.rsp_vld); end
            end else if (c == 5) begin
                n_checks++; if (bus3.rsp_vld !== 4'b0001 || bus3.rsp_data !== 16'h00A5 || bus3.busy !== 1'b1) begin n_fail++; $display("FAIL lat_rsp got %b/%h busy %b exp 0001/00a5 busy 1", bus3.rsp_vld, bus3.rsp_data, bus3.busy); end
            end else begin
                n_checks++; if (bus3.busy !== 1'b0 || bus3.rsp_vld !== 4'b0000) begin n_fail++; $display("FAIL lat_done got busy %b rsp %b exp 0/0000", bus3.busy, bus3.rsp_vld); end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        bus1.req_vld = 4'h0; bus1.req_addr = 32'h0;
        bus3.req_vld = 4'h0; bus3.req_addr = 32'h0;
        test_reset();
        test_single();
`ifndef FWD_ARB_PRIO_EN
        test_contention();
`else
        test_priority();
`endif
        test_back_to_back();
        test_reset_mid_flight();
        test_latency_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fwd_lkp_arb.md
# fwd_lkp_arb

Round-robin arbiter that shares the single forwarding-lookup read port of the forwarding lookup table among `REQ_NUM` per-channel forwarding engines. It accepts lookup requests with a valid/ready handshake and drives the table's `fwd_rden`/`fwd_addr`. It captures `fwd_data` after the fixed table latency and returns it to the originating requester with a one-cycle valid strobe. It sits between the per-channel forwarding engines and the `FwdLkp` forwarding port; host-bus access to the table is unaffected.

## Interface
Parameters:
- `REQ_NUM`, 4: number of requesters, 2..8.
- `LKP_LAT`, 1: cycles from `fwd_rden` to valid `fwd_data`, 1..4.
- `AW`, 8: lookup address width.
- `DW`, 12+`` `CHANNEL_NUM ``: lookup data width.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: system clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_vld`, in, `REQ_NUM`: per-requester lookup request.
- `req_addr`, in, `REQ_NUM*AW`: request addresses; requester i owns bits `[i*AW +: AW]`.
- `req_rdy`, out, `REQ_NUM`: one-hot grant (combinational); handshake when `req_vld[i] & req_rdy[i]`.
- `rsp_vld`, out, `REQ_NUM`: one-hot response strobe, registered.
- `rsp_data`, out, `DW`: response data, valid when any `rsp_vld` bit is high, registered.
- `fwd_rden`, out, 1: table read enable, registered.
- `fwd_addr`, out, `AW`: table read address, registered.
- `fwd_data`, in, `DW`: table read data.
- `busy`, out, 1: high while any lookup is in flight.

## Operation
- **Grant rule**
  - `req_rdy` is the combinational round-robin grant over `req_vld`, starting at pointer `ptr`.
  - At most one bit of `req_rdy` is set; `req_rdy` is all-zero when `req_vld` is zero.
  - Requesters must not derive `req_vld` from `req_rdy`.
- **Pointer update:** on a handshake by requester g, `ptr <= (g+1) mod REQ_NUM`. No handshake leaves `ptr` unchanged.
- **Issue:** on a handshake, the next cycle has `fwd_rden=1` and `fwd_addr=req_addr[g]`. Otherwise `fwd_rden=0` and `fwd_addr` holds its last value.
- **Tag pipeline**
  - The requester index and a valid bit shift through `LKP_LAT` stages, aligned with `fwd_data`.
  - When the last stage is valid, the next cycle has `rsp_vld[idx]=1` and `rsp_data=fwd_data`.
  - `rsp_data` holds its value when no response is being returned.
- **busy:** OR of `fwd_rden`, all tag-pipeline valid bits and any bit of `rsp_vld`.
- **Throughput:** one lookup per cycle; a single requester holding `req_vld` high is granted every cycle.
- **Responses:** always returned in issue order; there is no backpressure on responses.

## Timing
- Handshake in cycle T → `fwd_rden` in T+1 → `fwd_data` sampled in T+1+`LKP_LAT` → `rsp_vld` in T+2+`LKP_LAT`.
- Reset values: `fwd_rden=0`, `fwd_addr=0`, `rsp_vld=0`, `rsp_data=0`, `ptr=0`, tag pipeline cleared, `busy=0`.
- `rst` asserted mid-operation:
  - In-flight lookups are discarded with no `rsp_vld`.
  - `req_rdy` is forced to 0 while `rst` is high.
- All `req_vld` high: grants rotate 0,1,2,…,`REQ_NUM`-1,0 on consecutive cycles.
- Pointer wrap: a grant to requester `REQ_NUM`-1 sets `ptr=0`.

## Configuration
- `FWD_ARB_PRIO_EN` defined:
  - Requester 0 has strict priority; it is granted whenever `req_vld[0]=1`.
  - Requesters 1..`REQ_NUM`-1 share round-robin among themselves.
  - `ptr` spans 1..`REQ_NUM`-1, resets to 1, and is not updated on requester-0 grants.
- Not defined: pure round-robin over all requesters, as described above.

## Structure
- Shared package constants (`squat.vh`): `` `CHANNEL_NUM ``, `` `FWD_AW ``=8, `` `FWD_DW ``=12+`` `CHANNEL_NUM ``.
- One sub-module, `fwd_rr_arb`:
  - Parameterised combinational round-robin grant plus pointer register.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `gnt` and the encoded index.
- The tag pipeline and the response register stay in `fwd_lkp_arb`.

## Test plan
- **Single request:** `LKP_LAT=1`, requester 2 presents addr 0x3C in cycle 0, table returns 0x0A5 → `req_rdy=0100` in cycle 0, `fwd_rden`/`fwd_addr=0x3C` in cycle 1, `rsp_vld=0100` with `rsp_data=0x0A5` in cycle 3.
- **Full contention:** all four `req_vld` held high for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3; responses return in the same order, one per cycle.
- **Back-to-back from one requester:** requester 1 issues addrs 0x10,0x11,0x12 on consecutive cycles → three consecutive `fwd_rden` cycles; three `rsp_vld[1]` pulses with the matching data.
- **Reset mid-flight:** `rst` asserted in the cycle after `fwd_rden` → no `rsp_vld` ever appears for that lookup; all outputs 0 and `ptr=0` after reset.
- **Priority mode:** with `FWD_ARB_PRIO_EN`, `req_vld=1111` held high → requester 0 granted every cycle; after `req_vld[0]` drops, grants rotate 1,2,3.
- **Latency sweep:** `LKP_LAT=3` → `rsp_vld` arrives 5 cycles after the handshake; `busy` stays high throughout and falls the cycle after the last `rsp_vld`.
